rc4_decrypt_fsm: RTL

//   RC4 PRGA + decrypt stage, directly downstream of the key-scheduling FSM. After
//   KSA finishes scrambling s_RAM, this block generates keystream bytes from s_RAM,

---
 rtl/rc4_decrypt_fsm_if.sv | 31 +++
 rtl/rc4_decrypt_fsm.sv | 139 +++++++++++++
 2 files changed

// File: rtl/rc4_decrypt_fsm_if.sv
// Bus bundle between the RC4 PRGA/decrypt FSM and its s_RAM, encrypted ROM and decrypted RAM.
// Handshake: start is a request sampled only while the FSM is idle; finish is a one-cycle completion pulse.
interface rc4_decrypt_fsm_if #(
   parameter int MSG_AW = 5
);
   logic              start;
   logic              finish;
   logic              valid;
   logic [7:0]        s_address;
   logic [7:0]        s_data;
   logic              s_wren;
   logic [7:0]        s_q;
   logic [MSG_AW-1:0] e_address;
   logic [7:0]        e_q;
   logic [MSG_AW-1:0] d_address;
   logic [7:0]        d_data;
   logic              d_wren;
   logic [3:0]        fsm_state;

   modport master (
      input  start, s_q, e_q,
      output finish, valid, s_address, s_data, s_wren,
             e_address, d_address, d_data, d_wren, fsm_state
   );

   modport slave (
      output start, s_q, e_q,
      input  finish, valid, s_address, s_data, s_wren,
             e_address, d_address, d_data, d_wren, fsm_state
   );
endinterface

// File: rtl/rc4_decrypt_fsm.sv
// RC4 keystream generation over a KSA-scrambled s_RAM, XOR with the encrypted ROM into the
// decrypted RAM, tracking whether every plaintext byte is a lowercase letter or space.
module rc4_decrypt_fsm #(
   parameter int MSG_LEN          = 32,
   parameter int MSG_AW           = 5,
   parameter int ABORT_ON_INVALID = 1
) (
   input  logic             clock,
   input  logic             reset,
   rc4_decrypt_fsm_if.master bus
);

   typedef enum logic [3:0] {
      IDLE, INIT, INC_I, RD_SI_A, RD_SI_L, CALC_J, RD_SJ_A, RD_SJ_L,
      WR_I, WR_J, RD_F_A, RD_F_L, WR_D, CHK, DONE
   } state_t;

   localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

   state_t            state, next;
   logic [7:0]        i, j, si, sj, f, ek;
   logic [MSG_AW-1:0] k;
   logic              valid_q;
   logic [7:0]        s_addr_q, s_data_q, d_data_q;
   logic [MSG_AW-1:0] e_addr_q, d_addr_q;

   logic [7:0] plain;
   logic [7:0] f_addr;
   logic       printable;
   logic       stop_run;

   assign plain     = f ^ ek;
   assign f_addr    = si + sj;
   assign printable = (plain == 8'h20) || ((plain >= 8'h61) && (plain <= 8'h7A));
   assign stop_run  = (k == K_LAST) || ((ABORT_ON_INVALID != 0) && !valid_q);

   assign bus.valid     = valid_q;
   assign bus.fsm_state = state;

   // Memory buses keep their last value outside the states that use them.
   always_comb begin
      next          = state;
      bus.finish    = 1'b0;
      bus.s_address = s_addr_q;
      bus.s_data    = s_data_q;
      bus.s_wren    = 1'b0;
      bus.e_address = e_addr_q;
      bus.d_address = d_addr_q;
      bus.d_data    = d_data_q;
      bus.d_wren    = 1'b0;
      case (state)
         IDLE:    if (bus.start) next = INIT;
         INIT:    next = INC_I;
         INC_I:   next = RD_SI_A;
         RD_SI_A: begin bus.s_address = i; next = RD_SI_L; end
         RD_SI_L: begin bus.s_address = i; next = CALC_J; end
         CALC_J:  next = RD_SJ_A;
         RD_SJ_A: begin bus.s_address = j; next = RD_SJ_L; end
         RD_SJ_L: begin bus.s_address = j; next = WR_I; end
         WR_I: begin
            bus.s_address = i;
            bus.s_data    = sj;
            bus.s_wren    = 1'b1;
            next          = WR_J;
         end
         WR_J: begin
            bus.s_address = j;
            bus.s_data    = si;
            bus.s_wren    = 1'b1;
            next          = RD_F_A;
         end
         RD_F_A: begin
            bus.s_address = f_addr;
            bus.e_address = k;
            next          = RD_F_L;
         end
         RD_F_L: begin
            bus.s_address = f_addr;
            bus.e_address = k;
            next          = WR_D;
         end
         WR_D: begin
            bus.d_address = k;
            bus.d_data    = plain;
            bus.d_wren    = 1'b1;
            next          = CHK;
         end
         CHK:     next = stop_run ? DONE : INC_I;
         DONE:    begin bus.finish = 1'b1; next = IDLE; end
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         i        <= 8'h00;
         j        <= 8'h00;
         k        <= '0;
         si       <= 8'h00;
         sj       <= 8'h00;
         f        <= 8'h00;
         ek       <= 8'h00;
         valid_q  <= 1'b0;
         s_addr_q <= 8'h00;
         s_data_q <= 8'h00;
         d_data_q <= 8'h00;
         e_addr_q <= '0;
         d_addr_q <= '0;
      end else begin
         state    <= next;
         s_addr_q <= bus.s_address;
         s_data_q <= bus.s_data;
         d_data_q <= bus.d_data;
         e_addr_q <= bus.e_address;
         d_addr_q <= bus.d_address;
         case (state)
            INIT: begin
               i       <= 8'h00;
               j       <= 8'h00;
               k       <= '0;
               valid_q <= 1'b1;
            end
            INC_I:   i  <= i + 8'h01;
            RD_SI_L: si <= bus.s_q;
            CALC_J:  j  <= j + si;
            RD_SJ_L: sj <= bus.s_q;
            RD_F_L: begin
               f  <= bus.s_q;
               ek <= bus.e_q;
            end
            WR_D:    if (!printable) valid_q <= 1'b0;
            CHK:     if (!stop_run) k <= k + 1'b1;
            default: ;
         endcase
      end
   end

endmodule
